// File: rtl/ascon_cipher_serializer.sv
// ascon_cipher_serializer: streams captured ASCON ciphertext words as 32-bit
// valid/ready beats, big-endian within each word, with a partial final word.

package ascon_cipher_serializer_pkg;

  localparam int unsigned WORD_W = 64;
  localparam int unsigned STATE_WORDS = 5;

  // Ciphertext state: index k selects 64-bit word k, word 0 in bits [63:0]
  typedef logic [STATE_WORDS-1:0][WORD_W-1:0] type_state;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

endpackage

module ascon_cipher_serializer
  import ascon_cipher_serializer_pkg::*;
#(
  parameter int unsigned NB_WORDS = 4,
  parameter int unsigned OUT_W    = 32
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               load_i,
  input  type_state          cypher_i,
  input  logic [3:0]         last_bytes_i,
  output logic [OUT_W-1:0]   data_o,
  output logic [OUT_W/8-1:0] keep_o,
  output logic               valid_o,
  input  logic               ready_i,
  output logic               last_o,
  output logic               busy_o,
  output logic               done_o
);

  localparam int unsigned BEAT_W    = 4;
  localparam int unsigned LAST_FULL = 2 * (NB_WORDS - 1);
  localparam int unsigned STATE_W   = STATE_WORDS * WORD_W;
  // Keeps only words 0..NB_WORDS-1 at capture time
  localparam logic [STATE_W-1:0] CAP_MASK =
    {STATE_W{1'b1}} >> (WORD_W * (STATE_WORDS - NB_WORDS));

  // Reject unsupported parameterisations at elaboration
  if ((OUT_W != 32) || (NB_WORDS < 1) || (NB_WORDS > STATE_WORDS)) begin : g_param_check
    $error("ascon_cipher_serializer: OUT_W must be 32 and NB_WORDS 1..5");
  end

  state_e            state_q, state_d;
  type_state         words_q, words_d;
  logic [3:0]        lb_q, lb_d;
  logic [BEAT_W-1:0] beat_idx_q, beat_idx_d;
  logic [BEAT_W-1:0] last_idx_q, last_idx_d;
  logic              done_q, done_d;

  logic [3:0]        lb_norm_c;
  logic              is_final_c;

  // MSB-aligned byte enables for n valid bytes (n = 1..4)
  function automatic logic [3:0] keep_mask(input logic [3:0] n);
    case (n)
      4'd1:    keep_mask = 4'b1000;
      4'd2:    keep_mask = 4'b1100;
      4'd3:    keep_mask = 4'b1110;
      default: keep_mask = 4'b1111;
    endcase
  endfunction

  // Out-of-range byte counts collapse to a full final word
  assign lb_norm_c  = ((last_bytes_i == 4'd0) || (last_bytes_i > 4'd8)) ? 4'd8 : last_bytes_i;
  assign is_final_c = (beat_idx_q == last_idx_q);

  // State and datapath registers with synchronous reset
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      words_q    <= '0;
      lb_q       <= 4'd0;
      beat_idx_q <= '0;
      last_idx_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      words_q    <= words_d;
      lb_q       <= lb_d;
      beat_idx_q <= beat_idx_d;
      last_idx_q <= last_idx_d;
      done_q     <= done_d;
    end
  end

  // Next-state: capture in IDLE, advance beat index on each handshake in SEND
  always_comb begin
    state_d    = state_q;
    words_d    = words_q;
    lb_d       = lb_q;
    beat_idx_d = beat_idx_q;
    last_idx_d = last_idx_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_i) begin
          words_d    = type_state'(cypher_i & CAP_MASK);
          lb_d       = lb_norm_c;
          beat_idx_d = '0;
          last_idx_d = (lb_norm_c > 4'd4) ? BEAT_W'(LAST_FULL + 1) : BEAT_W'(LAST_FULL);
          state_d    = SEND;
        end
      end
      SEND: begin
        if (ready_i) begin
          if (is_final_c) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            beat_idx_d = beat_idx_q + BEAT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded purely from registered state
  always_comb begin
    logic [WORD_W-1:0] word_c;
    logic [31:0]       half_c;
    logic [3:0]        keep_c;
    logic              final_word_c;

    word_c       = words_q[beat_idx_q[3:1]];
    half_c       = beat_idx_q[0] ? word_c[31:0] : word_c[63:32];
    final_word_c = (beat_idx_q[3:1] == 3'(NB_WORDS - 1));
    if (!final_word_c) begin
      keep_c = 4'b1111;
    end else if (!beat_idx_q[0]) begin
      keep_c = (lb_q > 4'd4) ? 4'b1111 : keep_mask(lb_q);
    end else begin
      keep_c = keep_mask(lb_q - 4'd4);
    end

    data_o  = '0;
    keep_o  = '0;
    valid_o = 1'b0;
    last_o  = 1'b0;
    busy_o  = 1'b0;
    done_o  = done_q;
    if (state_q == SEND) begin
      valid_o = 1'b1;
      busy_o  = 1'b1;
      last_o  = is_final_c;
      keep_o  = keep_c;
      for (int unsigned b = 0; b < 4; b++) begin
        data_o[b*8 +: 8] = keep_c[b] ? half_c[b*8 +: 8] : 8'h00;
      end
    end
  end

endmodule

// File: tb/tb_ascon_cipher_serializer.sv
// Bench for ascon_cipher_serializer: scoreboard of expected beats built from a
// reference model at load time, checked by a negedge monitor.

module tb_ascon_cipher_serializer;
  import ascon_cipher_serializer_pkg::*;

  localparam int unsigned NB = 4;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } beat_t;

  logic        clk;
  logic        reset_i;
  logic        load_i;
  type_state   cypher_i;
  logic [3:0]  last_bytes_i;
  logic [31:0] data_o;
  logic [3:0]  keep_o;
  logic        valid_o;
  logic        ready_i;
  logic        last_o;
  logic        busy_o;
  logic        done_o;

  int          n_checks;
  int          n_errors;
  beat_t       exp_q[$];
  logic [63:0] words[5];
  logic        mon_en;
  logic        exp_done;
  logic        tgl_mode;

  ascon_cipher_serializer #(.NB_WORDS(NB), .OUT_W(32)) dut (
    .clock_i      (clk),
    .reset_i      (reset_i),
    .load_i       (load_i),
    .cypher_i     (cypher_i),
    .last_bytes_i (last_bytes_i),
    .data_o       (data_o),
    .keep_o       (keep_o),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .last_o       (last_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] apply_keep(input logic [31:0] d, input logic [3:0] k);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[b*8 +: 8] = k[b] ? d[b*8 +: 8] : 8'h00;
    return r;
  endfunction

  // Reference model: expected beat sequence for the current words[] and lb
  task automatic push_exp(input logic [3:0] lb);
    logic [3:0] lbn;
    logic [3:0] k;
    beat_t      e;
    lbn = ((lb == 4'd0) || (lb > 4'd8)) ? 4'd8 : lb;
    for (int w = 0; w < NB; w++) begin
      if (w < NB - 1) begin
        e = '{data: words[w][63:32], keep: 4'hF, last: 1'b0}; exp_q.push_back(e);
        e = '{data: words[w][31:0],  keep: 4'hF, last: 1'b0}; exp_q.push_back(e);
      end else if (lbn <= 4'd4) begin
        k = ~(4'hF >> lbn);
        e = '{data: apply_keep(words[w][63:32], k), keep: k, last: 1'b1}; exp_q.push_back(e);
      end else begin
        e = '{data: words[w][63:32], keep: 4'hF, last: 1'b0}; exp_q.push_back(e);
        k = ~(4'hF >> (lbn - 4'd4));
        e = '{data: apply_keep(words[w][31:0], k), keep: k, last: 1'b1}; exp_q.push_back(e);
      end
    end
  endtask

  // Called at posedge+1 with the DUT idle; captured on the next edge
  task automatic load_msg(input logic [3:0] lb);
    for (int i = 0; i < 5; i++) cypher_i[i] = words[i];
    last_bytes_i = lb;
    load_i = 1'b1;
    @(posedge clk); #1;
    load_i = 1'b0;
    push_exp(lb);
  endtask

  // Returns at posedge+1 right after the final handshake (the done cycle)
  task automatic drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      check_eq({tag, "_timeout"}, 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
  endtask

  // Ready driver: constant 1 or the 1,0,0,1,0,1 stall pattern
  initial begin
    logic [5:0] pat;
    int k;
    pat = 6'b101001;
    k = 0;
    ready_i = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (tgl_mode) begin
        ready_i = pat[k % 6];
        k++;
      end else begin
        ready_i = 1'b1;
        k = 0;
      end
    end
  end

  // Monitor: compares every cycle against the scoreboard head
  always @(negedge clk) begin
    beat_t e;
    if (mon_en) begin
      check_eq("done", 64'(done_o), 64'(exp_done));
      exp_done = 1'b0;
      check_eq("valid", 64'(valid_o), 64'(exp_q.size() != 0));
      check_eq("busy", 64'(busy_o), 64'(exp_q.size() != 0));
      if (valid_o && exp_q.size() != 0) begin
        e = exp_q[0];
        check_eq("data", 64'(data_o), 64'(e.data));
        check_eq("keep", 64'(keep_o), 64'(e.keep));
        check_eq("last", 64'(last_o), 64'(e.last));
        if (ready_i) begin
          exp_done = e.last;
          void'(exp_q.pop_front());
        end
      end else if (!valid_o) begin
        check_eq("idle_data", 64'(data_o), 64'd0);
        check_eq("idle_keep", 64'(keep_o), 64'd0);
        check_eq("idle_last", 64'(last_o), 64'd0);
      end
    end else begin
      exp_done = 1'b0;
    end
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    mon_en   = 1'b0;
    exp_done = 1'b0;
    tgl_mode = 1'b0;
    reset_i  = 1'b1;
    load_i   = 1'b0;
    cypher_i = '0;
    last_bytes_i = 4'd0;
    words[0] = 64'h0011223344556677;
    words[1] = 64'h8899AABBCCDDEEFF;
    words[2] = 64'h0123456789ABCDEF;
    words[3] = 64'hFEDCBA9876543210;
    words[4] = 64'hDEADBEEFCAFEF00D;

    repeat (3) @(posedge clk);
    #1;
    reset_i = 1'b0;
    check_eq("rst_valid", 64'(valid_o), 64'd0);
    check_eq("rst_busy",  64'(busy_o),  64'd0);
    check_eq("rst_done",  64'(done_o),  64'd0);
    check_eq("rst_keep",  64'(keep_o),  64'd0);
    check_eq("rst_data",  64'(data_o),  64'd0);
    mon_en = 1'b1;

    // Full final word, then partial messages loaded in each done cycle
    load_msg(4'd8);  drain("lb8");
    check_eq("done_cycle", 64'(done_o), 64'd1);
    load_msg(4'd7);  drain("lb7");
    load_msg(4'd3);  drain("lb3");

    // Stalls on the consumer side
    tgl_mode = 1'b1;
    load_msg(4'd8);  drain("stall");
    tgl_mode = 1'b0;

    // Loads with different data while sending must be ignored
    load_msg(4'd5);
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 5; j++) cypher_i[j] = ~words[j];
      last_bytes_i = 4'd2;
      load_i = 1'b1;
      @(posedge clk); #1;
    end
    load_i = 1'b0;
    drain("midload");

    // Boundary byte counts
    load_msg(4'd1);  drain("lb1");
    load_msg(4'd0);  drain("lb0");
    load_msg(4'd12); drain("lb12");
    load_msg(4'd4);  drain("lb4");

    // Reset while beat 3 is presented
    load_msg(4'd8);
    begin
      int n;
      n = 0;
      while (exp_q.size() > 6 && n < 50) begin
        @(posedge clk); #1;
        n++;
      end
    end
    reset_i = 1'b1;
    mon_en  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_eq("mrst_valid", 64'(valid_o), 64'd0);
    check_eq("mrst_busy",  64'(busy_o),  64'd0);
    check_eq("mrst_done",  64'(done_o),  64'd0);
    check_eq("mrst_keep",  64'(keep_o),  64'd0);
    @(posedge clk); #1;
    reset_i = 1'b0;
    exp_q.delete();
    mon_en = 1'b1;
    words[0] = 64'h1122334455667788;
    words[1] = 64'h99AABBCCDDEEFF00;
    words[2] = 64'h0F1E2D3C4B5A6978;
    words[3] = 64'h8796A5B4C3D2E1F0;
    load_msg(4'd6);  drain("postrst");

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
